uart_frame_parser: RTL

- Sits directly downstream of the UART receiver and consumes its byte output and busy flag.
- Assembles received bytes into command frames: 0x55 0xAA, CMD, LEN, payload[LEN], CHK.
- Checks length and checksum, and enforces an inter-byte timeout.
- Presents the validated command, length and a readable payload buffer to the application logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 37 +++
 rtl/uart_frame_parser.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART command-frame parser.
package uart_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR2 = 3'd1,
    CMD  = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4,
    CHK  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one write port, one registered read port.
// Reads beyond DEPTH return zero; contents are never cleared.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 8'h00;
    end else if (int'(raddr_i) < DEPTH) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= 8'h00;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles UART bytes into 55 AA CMD LEN payload CHK frames, validating
// length, XOR checksum and inter-byte timeout.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int AW             = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_byte,
  input  logic          rx_busy,
  input  logic [AW-1:0] pl_addr,
  output logic [7:0]    pl_data,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic          frame_valid,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic          rx_busy_q;
  logic          strobe;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_tmp_q, cmd_tmp_d;
  logic [7:0]    len_tmp_q, len_tmp_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    frame_cmd_q, frame_cmd_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          buf_we;

  // Byte completes on the falling edge of the receiver busy flag.
  assign strobe = rx_busy_q & ~rx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_busy_q   <= 1'b0;
      tmo_q       <= '0;
      cmd_tmp_q   <= 8'h00;
      len_tmp_q   <= 8'h00;
      chk_q       <= 8'h00;
      idx_q       <= 8'h00;
      frame_cmd_q <= 8'h00;
      frame_len_q <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      rx_busy_q   <= rx_busy;
      tmo_q       <= tmo_d;
      cmd_tmp_q   <= cmd_tmp_d;
      len_tmp_q   <= len_tmp_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    cmd_tmp_d   = cmd_tmp_q;
    len_tmp_d   = len_tmp_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    // A strobe on the terminal count takes priority over the timeout.
    if (state_q == IDLE || strobe) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d      = '0;
      state_d    = IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == HDR0) state_d = HDR2;
        end
        HDR2: begin
          if (rx_byte == HDR1)      state_d = CMD;
          else if (rx_byte == HDR0) state_d = HDR2;
          else                      state_d = IDLE;
        end
        CMD: begin
          cmd_tmp_d = rx_byte;
          chk_d     = rx_byte;
          state_d   = LEN;
        end
        LEN: begin
          len_tmp_d = rx_byte;
          chk_d     = chk_q ^ rx_byte;
          if (rx_byte > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = IDLE;
          end else if (rx_byte == 8'h00) begin
            state_d = CHK;
          end else begin
            idx_d   = 8'h00;
            state_d = DATA;
          end
        end
        DATA: begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_byte;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_tmp_q - 8'd1) state_d = CHK;
        end
        CHK: begin
          if (rx_byte == chk_q) begin
            valid_d     = 1'b1;
            frame_cmd_d = cmd_tmp_q;
            frame_len_d = len_tmp_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  uart_frame_buf #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (buf_we),
    .waddr_i(idx_q[AW-1:0]),
    .wdata_i(rx_byte),
    .raddr_i(pl_addr),
    .rdata_o(pl_data)
  );

  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != IDLE);

endmodule
